// File: rtl/sram_controller_pkg.sv
// Shared definitions for the data-memory SRAM controller.
//   state_t    : access FSM states and their encodings
//   op_t       : latched operation type (read / write)
//   word_addr(): CPU byte address -> 17-bit SRAM word address
//   BASE_ADDR_DEFAULT / WAIT_CYCLES_DEFAULT : default controller parameters
package sram_controller_pkg;

  localparam int unsigned BASE_ADDR_DEFAULT   = 32'd1024;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;
  localparam int unsigned WORD_AW             = 17;
  localparam int unsigned SRAM_AW             = 18;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Each 32-bit word occupies two 16-bit SRAM locations. Addresses beyond the
  // 17-bit word space wrap silently.
  function automatic logic [WORD_AW-1:0] word_addr(input logic [31:0] byte_addr,
                                                   input logic [31:0] base);
    return WORD_AW'((byte_addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// SRAM controller: splits each 32-bit CPU load/store into two 16-bit SRAM
// accesses (low half, then high half), then idles WAIT_CYCLES cycles before
// reporting completion.
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   wr_en, rd_en   MEM-stage store / load request (store wins if both)
//   address        CPU byte address (word aligned)
//   writeData      store data
//   readData       load result, held until the next load overwrites it
//   ready          0 freezes the pipeline; 1 = access complete or no access
//   SRAM_ADDR      half-word address to SRAM
//   SRAM_WE_N      SRAM write strobe, active low
//   SRAM_DQ_out    data driven onto the SRAM DQ bus
//   SRAM_DQ_oe     1 = controller drives DQ
//   SRAM_DQ_in     data returned from SRAM
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT  // legal range 1..7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [31:0]          address,
  input  logic [31:0]          writeData,
  output logic [31:0]          readData,
  output logic                 ready,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N,
  output logic [15:0]          SRAM_DQ_out,
  output logic                 SRAM_DQ_oe,
  input  logic [15:0]          SRAM_DQ_in
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic [2:0]           wait_cnt;
  logic [WORD_AW-1:0]   addr_q;
  logic [31:0]          data_q;
  op_t                  op_q;
  logic                 req;

  assign req = wr_en | rd_en;

  // State register.
  // NOTE: reset is sampled on the clock edge like any other input, so it
  // lives inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path covered,
    // so no latch is inferred for state_next.
    state_next = state;
    unique case (state)
      IDLE:    if (req) state_next = LOW;
      LOW:     state_next = HIGH;
      HIGH:    state_next = WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter and load-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 3'd0;
      addr_q   <= '0;
      data_q   <= 32'd0;
      op_q     <= OP_READ;
      readData <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // the pre-edge values, independent of statement order.
      // The request is sampled only when accepted; later changes to the CPU
      // inputs cannot disturb an access in flight.
      if (state == IDLE && req) begin
        addr_q <= word_addr(address, 32'(BASE_ADDR));
        data_q <= writeData;
        op_q   <= wr_en ? OP_WRITE : OP_READ;
      end

      // Counter is zero on entry to WAIT because it is held clear elsewhere.
      if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;
      else               wait_cnt <= 3'd0;

      if (op_q == OP_READ) begin
        if (state == LOW)  readData[15:0]  <= SRAM_DQ_in;
        if (state == HIGH) readData[31:16] <= SRAM_DQ_in;
      end
    end
  end

  // State-derived outputs.
  always_comb begin
    ready       = 1'b1;
    SRAM_ADDR   = '0;
    SRAM_WE_N   = 1'b1;
    SRAM_DQ_out = 16'd0;
    SRAM_DQ_oe  = 1'b0;
    unique case (state)
      // A new request freezes the pipeline in the same cycle it appears.
      IDLE: ready = ~req;
      LOW: begin
        ready     = 1'b0;
        SRAM_ADDR = {addr_q, 1'b0};
        if (op_q == OP_WRITE) begin
          SRAM_WE_N   = 1'b0;
          SRAM_DQ_oe  = 1'b1;
          SRAM_DQ_out = data_q[15:0];
        end
      end
      HIGH: begin
        ready     = 1'b0;
        SRAM_ADDR = {addr_q, 1'b1};
        if (op_q == OP_WRITE) begin
          SRAM_WE_N   = 1'b0;
          SRAM_DQ_oe  = 1'b1;
          SRAM_DQ_out = data_q[31:16];
        end
      end
      WAIT:    ready = 1'b0;
      DONE:    ready = 1'b1;
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: a behavioural SRAM records every
// write strobe into a queue, and each scenario task pushes the strobes and
// load results it expects, then compares them as the DUT produces them.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int NC = 12;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } hw_wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = 32'd0, write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_dq_oe;
  logic [15:0] sram_dq_out, sram_dq_in;

  logic        wr_en4 = 1'b0, rd_en4 = 1'b0;
  logic [31:0] address4 = 32'd0, write_data4 = 32'd0;
  logic [31:0] read_data4;
  logic        ready4;
  logic [17:0] sram_addr4;
  logic        sram_we_n4, sram_dq_oe4;
  logic [15:0] sram_dq_out4;
  logic [15:0] sram_dq_in4 = 16'h1234;

  logic [15:0] mem     [1024];
  logic [15:0] ref_mem [1024];
  hw_wr_t      exp_wr[$], obs_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] last_rd;

  logic        rdy_tr  [NC];
  logic [17:0] addr_tr [NC];
  logic        we_tr   [NC];
  logic        oe_tr   [NC];
  logic [15:0] dq_tr   [NC];
  logic [31:0] rd_tr   [NC];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .writeData(write_data), .readData(read_data),
    .ready(ready), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_DQ_out(sram_dq_out), .SRAM_DQ_oe(sram_dq_oe), .SRAM_DQ_in(sram_dq_in)
  );

  sram_controller #(.WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .rd_en(rd_en4),
    .address(address4), .writeData(write_data4), .readData(read_data4),
    .ready(ready4), .SRAM_ADDR(sram_addr4), .SRAM_WE_N(sram_we_n4),
    .SRAM_DQ_out(sram_dq_out4), .SRAM_DQ_oe(sram_dq_oe4), .SRAM_DQ_in(sram_dq_in4)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 32'h1357 + 32'h0A5A);
  endfunction

  // Behavioural SRAM: every cycle with the strobe low is one half-word write.
  assign sram_dq_in = mem[sram_addr[9:0]];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (sram_we_n === 1'b0) begin
        obs_wr.push_back(hw_wr_t'{addr: sram_addr, data: (sram_dq_oe === 1'b1) ? sram_dq_out : 16'hxxxx});
        mem[sram_addr[9:0]] = sram_dq_out;
      end
    end
  end

  // Drives one request and records the DUT outputs for ncyc cycles; cycle 0
  // is the IDLE cycle in which the request is first presented.
  task automatic run_access(input bit is_wr, input bit both, input logic [31:0] addr,
                            input logic [31:0] data, input int hold, input int chg_cycle,
                            input logic [31:0] chg_addr, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        address = addr; write_data = data;
        wr_en = is_wr | both; rd_en = ~is_wr | both;
      end
      if (c >= hold) begin wr_en = 1'b0; rd_en = 1'b0; end
      if (c == chg_cycle) begin address = chg_addr; write_data = ~data; end
      #1;
      rdy_tr[c] = ready; addr_tr[c] = sram_addr; we_tr[c] = sram_we_n;
      oe_tr[c] = sram_dq_oe; dq_tr[c] = sram_dq_out; rd_tr[c] = read_data;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
    n_cmp++; if (sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", sram_dq_oe); end
    n_cmp++; if (sram_addr !== 18'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", sram_addr); end
    n_cmp++; if (sram_dq_out !== 16'd0) begin n_bad++; $display("FAIL reset_dq_out: got %h want 0000", sram_dq_out); end
    n_cmp++; if (sram_dq_out4 !== 16'd0) begin n_bad++; $display("FAIL reset_dq_out4: got %h want 0000", sram_dq_out4); end
    n_cmp++; if (read_data !== 32'd0) begin n_bad++; $display("FAIL reset_read_data: got %h want 0", read_data); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_idle: got %b want 1", ready); end
    rd_en = 1'b1; #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_req: got %b want 0", ready); end
    rd_en = 1'b0;
    @(negedge clk); rst = 1'b0;
    last_rd = 32'd0;
  endtask

  task automatic test_write_read();
    hw_wr_t e, o;
    logic [31:0] want;
    exp_wr.push_back(hw_wr_t'{addr: 18'd0, data: 16'hBEEF});
    exp_wr.push_back(hw_wr_t'{addr: 18'd1, data: 16'hDEAD});
    ref_mem[0] = 16'hBEEF; ref_mem[1] = 16'hDEAD;
    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1, -1, 32'd0, 7);
    for (int c = 0; c < 7; c++) begin
      n_cmp++; if (rdy_tr[c] !== 1'(c >= 5)) begin n_bad++; $display("FAIL wr_ready[%0d]: got %b want %b", c, rdy_tr[c], c >= 5); end
    end
    n_cmp++; if (addr_tr[1] !== 18'd0) begin n_bad++; $display("FAIL wr_low_addr: got %0d want 0", addr_tr[1]); end
    n_cmp++; if (addr_tr[2] !== 18'd1) begin n_bad++; $display("FAIL wr_high_addr: got %0d want 1", addr_tr[2]); end
    n_cmp++; if (dq_tr[1] !== 16'hBEEF || oe_tr[1] !== 1'b1) begin n_bad++; $display("FAIL wr_low_dq: got %h oe=%b want beef oe=1", dq_tr[1], oe_tr[1]); end
    n_cmp++; if (dq_tr[2] !== 16'hDEAD || oe_tr[2] !== 1'b1) begin n_bad++; $display("FAIL wr_high_dq: got %h oe=%b want dead oe=1", dq_tr[2], oe_tr[2]); end
    n_cmp++; if (we_tr[3] !== 1'b1 || oe_tr[3] !== 1'b0) begin n_bad++; $display("FAIL wr_wait_bus: got we_n=%b oe=%b want 1/0", we_tr[3], oe_tr[3]); end
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front(); n_cmp++;
      if (obs_wr.size() == 0) begin n_bad++; $display("FAIL wr_strobe: observed queue empty, want addr=%0d data=%h", e.addr, e.data); end
      else begin
        o = obs_wr.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL wr_strobe: got addr=%0d data=%h want addr=%0d data=%h", o.addr, o.data, e.addr, e.data); end
      end
    end

    exp_rd.push_back({ref_mem[1], ref_mem[0]});
    last_rd = {ref_mem[1], ref_mem[0]};
    run_access(1'b0, 1'b0, 32'd1024, 32'd0, 1, -1, 32'd0, 7);
    for (int c = 0; c < 7; c++) begin
      n_cmp++; if (rdy_tr[c] !== 1'(c >= 5) || we_tr[c] !== 1'b1 || oe_tr[c] !== 1'b0)
        begin n_bad++; $display("FAIL rd_cycle[%0d]: got ready=%b we_n=%b oe=%b want %b/1/0", c, rdy_tr[c], we_tr[c], oe_tr[c], c >= 5); end
    end
    want = exp_rd.pop_front();
    n_cmp++; if (rd_tr[5] !== want) begin n_bad++; $display("FAIL rd_data_done: got %h want %h", rd_tr[5], want); end
    n_cmp++; if (rd_tr[6] !== want) begin n_bad++; $display("FAIL rd_data_hold: got %h want %h", rd_tr[6], want); end
  endtask

  task automatic test_addr_map();
    logic [31:0] want;
    exp_rd.push_back({ref_mem[5], ref_mem[4]});
    last_rd = {ref_mem[5], ref_mem[4]};
    run_access(1'b0, 1'b0, 32'd1032, 32'd0, 1, -1, 32'd0, 6);
    n_cmp++; if (addr_tr[0] !== 18'd0) begin n_bad++; $display("FAIL map_idle_addr: got %0d want 0", addr_tr[0]); end
    n_cmp++; if (addr_tr[1] !== 18'd4) begin n_bad++; $display("FAIL map_low_addr: got %0d want 4", addr_tr[1]); end
    n_cmp++; if (addr_tr[2] !== 18'd5) begin n_bad++; $display("FAIL map_high_addr: got %0d want 5", addr_tr[2]); end
    want = exp_rd.pop_front();
    n_cmp++; if (rd_tr[5] !== want) begin n_bad++; $display("FAIL map_rd_data: got %h want %h", rd_tr[5], want); end
  endtask

  task automatic test_simultaneous();
    hw_wr_t e, o;
    logic [31:0] want;
    exp_wr.push_back(hw_wr_t'{addr: 18'd8, data: 16'h5678});
    exp_wr.push_back(hw_wr_t'{addr: 18'd9, data: 16'h1234});
    ref_mem[8] = 16'h5678; ref_mem[9] = 16'h1234;
    run_access(1'b1, 1'b1, 32'd1040, 32'h12345678, 1, -1, 32'd0, 6);
    n_cmp++; if (we_tr[1] !== 1'b0 || we_tr[2] !== 1'b0) begin n_bad++; $display("FAIL both_we_n: got %b%b want 00", we_tr[1], we_tr[2]); end
    n_cmp++; if (rd_tr[5] !== last_rd) begin n_bad++; $display("FAIL both_rd_unchanged: got %h want %h", rd_tr[5], last_rd); end
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front(); n_cmp++;
      if (obs_wr.size() == 0) begin n_bad++; $display("FAIL both_strobe: observed queue empty, want addr=%0d data=%h", e.addr, e.data); end
      else begin
        o = obs_wr.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL both_strobe: got addr=%0d data=%h want addr=%0d data=%h", o.addr, o.data, e.addr, e.data); end
      end
    end
    exp_rd.push_back({ref_mem[9], ref_mem[8]});
    last_rd = {ref_mem[9], ref_mem[8]};
    run_access(1'b0, 1'b0, 32'd1040, 32'd0, 1, -1, 32'd0, 6);
    want = exp_rd.pop_front();
    n_cmp++; if (rd_tr[5] !== want) begin n_bad++; $display("FAIL both_readback: got %h want %h", rd_tr[5], want); end
  endtask

  task automatic test_mid_op_change();
    hw_wr_t e, o;
    logic [31:0] want;
    // Read held into WAIT, then dropped while the address moves elsewhere.
    exp_rd.push_back({ref_mem[5], ref_mem[4]});
    last_rd = {ref_mem[5], ref_mem[4]};
    run_access(1'b0, 1'b0, 32'd1032, 32'd0, 3, 3, 32'd1024, 7);
    for (int c = 0; c < 7; c++) begin
      n_cmp++; if (rdy_tr[c] !== 1'(c >= 5)) begin n_bad++; $display("FAIL mid_ready[%0d]: got %b want %b", c, rdy_tr[c], c >= 5); end
    end
    want = exp_rd.pop_front();
    n_cmp++; if (rd_tr[5] !== want) begin n_bad++; $display("FAIL mid_rd_data: got %h want %h", rd_tr[5], want); end
    // Write whose address and data change during LOW.
    exp_wr.push_back(hw_wr_t'{addr: 18'd12, data: 16'hF00D});
    exp_wr.push_back(hw_wr_t'{addr: 18'd13, data: 16'hCAFE});
    ref_mem[12] = 16'hF00D; ref_mem[13] = 16'hCAFE;
    run_access(1'b1, 1'b0, 32'd1048, 32'hCAFEF00D, 1, 1, 32'd1056, 6);
    n_cmp++; if (addr_tr[2] !== 18'd13) begin n_bad++; $display("FAIL mid_high_addr: got %0d want 13", addr_tr[2]); end
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front(); n_cmp++;
      if (obs_wr.size() == 0) begin n_bad++; $display("FAIL mid_strobe: observed queue empty, want addr=%0d data=%h", e.addr, e.data); end
      else begin
        o = obs_wr.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL mid_strobe: got addr=%0d data=%h want addr=%0d data=%h", o.addr, o.data, e.addr, e.data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    exp_rd.push_back({ref_mem[9], ref_mem[8]});
    exp_rd.push_back({ref_mem[9], ref_mem[8]});
    last_rd = {ref_mem[9], ref_mem[8]};
    run_access(1'b0, 1'b0, 32'd1040, 32'd0, 99, -1, 32'd0, 8);
    n_cmp++; if (rdy_tr[5] !== 1'b1) begin n_bad++; $display("FAIL b2b_done_ready: got %b want 1", rdy_tr[5]); end
    n_cmp++; if (rdy_tr[6] !== 1'b0) begin n_bad++; $display("FAIL b2b_restart_ready: got %b want 0", rdy_tr[6]); end
    n_cmp++; if (addr_tr[7] !== 18'd8) begin n_bad++; $display("FAIL b2b_second_low: got %0d want 8", addr_tr[7]); end
    want = exp_rd.pop_front();
    n_cmp++; if (rd_tr[5] !== want) begin n_bad++; $display("FAIL b2b_first_data: got %h want %h", rd_tr[5], want); end
    repeat (6) @(negedge clk);
    #1;
    want = exp_rd.pop_front();
    n_cmp++; if (read_data !== want || ready !== 1'b1) begin n_bad++; $display("FAIL b2b_second_data: got %h ready=%b want %h ready=1", read_data, ready, want); end
  endtask

  task automatic test_reset_mid();
    hw_wr_t e, o;
    logic [31:0] want;
    // The HIGH cycle is fully presented before the synchronous reset edge.
    exp_wr.push_back(hw_wr_t'{addr: 18'd20, data: 16'h5A5A});
    exp_wr.push_back(hw_wr_t'{addr: 18'd21, data: 16'hA5A5});
    ref_mem[20] = 16'h5A5A; ref_mem[21] = 16'hA5A5;
    run_access(1'b1, 1'b0, 32'd1064, 32'hA5A55A5A, 1, -1, 32'd0, 3);
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d want %0d", dut.state, IDLE); end
    n_cmp++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL rstmid_bus: got we_n=%b oe=%b want 1/0", sram_we_n, sram_dq_oe); end
    n_cmp++; if (read_data !== 32'd0) begin n_bad++; $display("FAIL rstmid_read_data: got %h want 0", read_data); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", ready); end
    rst = 1'b0;
    last_rd = 32'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (ready !== 1'b1 || dut.state !== IDLE) begin n_bad++; $display("FAIL rstmid_no_done[%0d]: got ready=%b state=%0d want 1/%0d", c, ready, dut.state, IDLE); end
    end
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front(); n_cmp++;
      if (obs_wr.size() == 0) begin n_bad++; $display("FAIL rstmid_strobe: observed queue empty, want addr=%0d data=%h", e.addr, e.data); end
      else begin
        o = obs_wr.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL rstmid_strobe: got addr=%0d data=%h want addr=%0d data=%h", o.addr, o.data, e.addr, e.data); end
      end
    end
    exp_rd.push_back({ref_mem[21], ref_mem[20]});
    run_access(1'b0, 1'b0, 32'd1064, 32'd0, 1, -1, 32'd0, 6);
    want = exp_rd.pop_front();
    n_cmp++; if (rd_tr[5] !== want) begin n_bad++; $display("FAIL rstmid_readback: got %h want %h", rd_tr[5], want); end
  endtask

  task automatic test_wait4();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin rd_en4 = 1'b1; address4 = 32'd1024; end
      else rd_en4 = 1'b0;
      #1;
      n_cmp++; if (ready4 !== 1'(c >= 7)) begin n_bad++; $display("FAIL w4_ready[%0d]: got %b want %b", c, ready4, c >= 7); end
      if (c == 2) begin
        n_cmp++; if (sram_addr4 !== 18'd1 || sram_we_n4 !== 1'b1 || sram_dq_oe4 !== 1'b0)
          begin n_bad++; $display("FAIL w4_high_bus: got addr=%0d we_n=%b oe=%b want 1/1/0", sram_addr4, sram_we_n4, sram_dq_oe4); end
      end
      if (c == 7) begin
        n_cmp++; if (read_data4 !== 32'h12341234) begin n_bad++; $display("FAIL w4_rd_data: got %h want 12341234", read_data4); end
      end
    end
  endtask

  task automatic test_no_stray_writes();
    n_cmp++; if (obs_wr.size() != 0 || exp_wr.size() != 0)
      begin n_bad++; $display("FAIL stray_strobes: got %0d unmatched observed, %0d unmet expected, want 0/0", obs_wr.size(), exp_wr.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_write_read();
    test_addr_map();
    test_simultaneous();
    test_mid_op_change();
    test_back_to_back();
    test_reset_mid();
    test_wait4();
    test_no_stray_writes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- BASE_ADDR, 1024, data-memory base subtracted from the CPU address.
- WAIT_CYCLES, 2, idle SRAM cycles inserted after both half-word accesses (legal range 1..7).

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  MEM-stage store request.
- rd_en  in  1  MEM-stage load request.
- address  in  32  CPU byte address, word-aligned.
- writeData  in  32  store data.
- readData  out  32  load result.
- ready  out  1  0 = freeze pipeline, 1 = access complete or no access.
- SRAM_ADDR  out  18  half-word address to SRAM.
- SRAM_WE_N  out  1  SRAM write strobe, active-low.
- SRAM_DQ_out  out  16  data driven to SRAM.
- SRAM_DQ_oe  out  1  1 = controller drives the DQ bus.
- SRAM_DQ_in  in  16  data returned from SRAM.

Function
REQ-003 FSM states: IDLE, LOW, HIGH, WAIT, DONE; encoding comes from the shared package.
REQ-004 IDLE with (wr_en|rd_en)=1 -> LOW next cycle; the operation is latched as a write if wr_en=1, otherwise as a read.
- wr_en has priority when both are high.
REQ-005 Transitions:
- LOW -> HIGH -> WAIT.
- WAIT is held for exactly WAIT_CYCLES cycles using a 3-bit counter cleared on entry, then -> DONE.
- DONE -> IDLE unconditionally.
REQ-006 ready is combinational and equals 0 when (state=IDLE and (wr_en|rd_en)=1) or state is LOW, HIGH or WAIT; otherwise it equals 1.
REQ-007 Latency: with WAIT_CYCLES=2, a request first seen at edge 0 yields ready=1 during the DONE cycle, which is cycle 5, for one cycle.
REQ-008 Word address is computed as wa = (address - BASE_ADDR) >> 2, truncated to 17 bits.
- In LOW, SRAM_ADDR = {wa,1'b0}.
- In HIGH, SRAM_ADDR = {wa,1'b1}.
- In all other states, SRAM_ADDR = 0.
REQ-009 Writes:
- In LOW, SRAM_DQ_out = writeData[15:0], SRAM_DQ_oe=1, SRAM_WE_N=0.
- In HIGH, SRAM_DQ_out = writeData[31:16], SRAM_DQ_oe=1, SRAM_WE_N=0.
- In all other states, SRAM_WE_N=1 and SRAM_DQ_oe=0.
REQ-010 Reads:
- SRAM_WE_N=1 and SRAM_DQ_oe=0 throughout.
- SRAM_DQ_in is captured into readData[15:0] at the end of LOW and into readData[31:16] at the end of HIGH.
REQ-011 readData holds its value until the next read's LOW capture; writes never modify readData.
REQ-012 The address, write data and operation type are latched on the IDLE->LOW edge.
- Changes to address, writeData, wr_en or rd_en during LOW, HIGH, WAIT or DONE are ignored.
REQ-013 If the request is deasserted mid-operation, the access still completes and DONE still occurs.
REQ-014 A request still asserted in the cycle after DONE (state IDLE) starts a new access; no back-to-back suppression is applied.
REQ-015 Only the lower 17 bits of wa are used; addresses outside SRAM range wrap with no error indication.

Reset
REQ-016 While rst=1 at a clock edge:
- state becomes IDLE.
- The wait counter and readData are cleared to 0.
- The latched address, data and operation are cleared to 0.
REQ-017 After reset, the registered and state-derived outputs are SRAM_WE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0 and SRAM_DQ_out=0.
- ready=1 when wr_en=rd_en=0.
- ready=0 when wr_en or rd_en is high, per REQ-006.
REQ-018 A reset asserted during LOW, HIGH or WAIT aborts the access with no DONE cycle.
- A write aborted this way may have completed only its low half.

Structure
REQ-019 The state typedef, state encodings and the BASE_ADDR default value belong in the shared pipeline package.
REQ-020 The design is a single module with no sub-module; the wait counter is inline.

Verification
REQ-021 The bench shall cover these directed scenarios:
- Write then read: wr_en, address=1024, writeData=0xDEADBEEF -> SRAM half-word 0 = 0xBEEF, half-word 1 = 0xDEAD, ready=0 for 5 cycles; then rd_en at address 1024 -> readData=0xDEADBEEF in the DONE cycle.
- Address mapping: address=1032 -> SRAM_ADDR=4 in LOW and 5 in HIGH.
- Simultaneous request: wr_en=rd_en=1 -> a write occurs (SRAM_WE_N=0 in LOW and HIGH) and readData is unchanged.
- Mid-operation changes: address changed and rd_en dropped during WAIT -> the access completes on the original address and ready returns to 1 at cycle 5.
- Reset during HIGH of a write -> next cycle state=IDLE, SRAM_WE_N=1, SRAM_DQ_oe=0, readData=0, and ready=1 when wr_en=rd_en=0.
- WAIT_CYCLES=4 -> ready first rises at cycle 7.
